// File: rtl/kf_operand_loader.sv
// kf_operand_loader: converts a two's-complement sample stream to
// sign-magnitude, buffers it and feeds NOPS operands into kf_top.
module kf_operand_loader #(
  parameter int W     = 24,
  parameter int FRAC  = 14,
  parameter int NOPS  = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  input  logic         kf_ready,
  output logic         kf_start,
  output logic [W-1:0] kf_data,
  output logic         busy,
  output logic [7:0]   sat_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int KW = (NOPS > 1) ? $clog2(NOPS) : 1;

  if (FRAC >= W || NOPS < 1 || DEPTH < NOPS) begin : g_bad_cfg
    $error("kf_operand_loader: bad parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [KW-1:0]   ld_k;
  logic            ld_last;

  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [W-1:0]    head;
  logic            push;
  logic            pop;

  logic            neg;
  logic            is_min;
  logic [W-1:0]    neg_v;
  logic [W-2:0]    mag;
  logic [W-1:0]    conv;

  // Sign-magnitude conversion; the most negative code saturates.
  assign neg    = s_data[W-1];
  assign is_min = neg && (s_data[W-2:0] == '0);
  assign neg_v  = -s_data;

  always_comb begin
    mag = s_data[W-2:0];
    if (is_min) begin
      mag = '1;
    end else if (neg) begin
      mag = neg_v[W-2:0];
    end
  end

  assign conv = {neg, mag};

  assign s_ready = (count != CW'(DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = (state == LOAD);
  assign head    = mem[rd_ptr];
  assign ld_last = (ld_k == KW'(NOPS - 1));
  assign busy    = (state != IDLE);

  // Sample storage; validity is tracked by the pointers only.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= conv;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase
    end
  end

  // Saturation event counter, sticky at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (push && is_min && sat_cnt != 8'hFF) begin
      sat_cnt <= sat_cnt + 8'd1;
    end
  end

  // State register and operand index within LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ld_k  <= '0;
    end else begin
      state <= state_n;
      if (state == LOAD && !ld_last) begin
        ld_k <= ld_k + 1'b1;
      end else begin
        ld_k <= '0;
      end
    end
  end

  // Next state and kf_top-facing outputs.
  always_comb begin
    state_n  = state;
    kf_start = 1'b0;
    kf_data  = '0;
    unique case (state)
      IDLE: begin
        kf_data = (count == '0) ? '0 : head;
        if (count >= CW'(NOPS) && kf_ready) begin
          state_n = START;
        end
      end
      START: begin
        kf_start = 1'b1;
        kf_data  = head;
        state_n  = LOAD;
      end
      LOAD: begin
        kf_data = head;
        if (ld_last) begin
          state_n = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!kf_ready) begin
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (kf_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_kf_operand_loader.sv
// tb_kf_operand_loader: directed vectors and run sequences
// for kf_operand_loader with default parameters.
module tb_kf_operand_loader;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         kf_ready = 1'b0;
  logic         s_ready;
  logic         kf_start;
  logic [W-1:0] kf_data;
  logic         busy;
  logic [7:0]   sat_cnt;

  int checks = 0;
  int failures = 0;
  int exp_sat = 0;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dout;
    int           sat;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  kf_operand_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .kf_ready (kf_ready),
    .kf_start (kf_start),
    .kf_data  (kf_data),
    .busy     (busy),
    .sat_cnt  (sat_cnt)
  );

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [W-1:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got s_ready=0 expected 1");
    end else begin
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic run_chk(input string name,
                         input logic [W-1:0] e0,
                         input logic [W-1:0] e1);
    int n;
    n = 0;
    kf_ready = 1'b1;
    while (!kf_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_start"}, kf_start, 1);
    check({name, "_d0a"}, kf_data, e0);
    @(negedge clk);
    check({name, "_start_pulse"}, kf_start, 0);
    check({name, "_d0b"}, kf_data, e0);
    @(negedge clk);
    check({name, "_d1"}, kf_data, e1);
    @(negedge clk);
    check({name, "_dz"}, kf_data, 0);
    check({name, "_busy"}, busy, 1);
    kf_ready = 1'b0;
    repeat (2) @(negedge clk);
    check({name, "_busy_wait"}, busy, 1);
    check({name, "_no_restart"}, kf_start, 0);
    kf_ready = 1'b1;
    @(negedge clk);
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    vecs[0] = '{24'hFF6000, 24'h80A000, 0};
    vecs[1] = '{24'h000000, 24'h000000, 0};
    vecs[2] = '{24'h800000, 24'hFFFFFF, 1};
    vecs[3] = '{24'h000001, 24'h000001, 0};
    vecs[4] = '{24'hFFFFFF, 24'h800001, 0};
    vecs[5] = '{24'h7FFFFF, 24'h7FFFFF, 0};
    vecs[6] = '{24'h800001, 24'hFFFFFF, 0};
    vecs[7] = '{24'hC00000, 24'hC00000, 0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_s_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", kf_start, 0);
    check("rst_data", kf_data, 0);
    check("rst_sat", sat_cnt, 0);

    kf_ready = 1'b1;
    push(24'h00C000);
    push(24'h00A000);
    run_chk("basic", 24'h00C000, 24'h00A000);

    for (int i = 0; i < 8; i += 2) begin
      push(vecs[i].din);
      push(vecs[i+1].din);
      exp_sat += vecs[i].sat + vecs[i+1].sat;
      check($sformatf("vec%0d_sat", i), sat_cnt, exp_sat);
      run_chk($sformatf("vec%0d", i), vecs[i].dout, vecs[i+1].dout);
    end

    kf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push(W'(i));
    end
    check("bp_full", s_ready, 0);
    s_valid = 1'b1;
    s_data  = 24'd5;
    repeat (3) @(negedge clk);
    check("bp_held", s_ready, 0);
    check("bp_no_start", kf_start, 0);
    check("bp_idle", busy, 0);
    check("bp_head", kf_data, 1);
    fork
      begin
        push(24'd5);
        push(24'd6);
      end
      begin
        run_chk("bp_run1", 24'd1, 24'd2);
        run_chk("bp_run2", 24'd3, 24'd4);
      end
    join
    run_chk("bp_run3", 24'd5, 24'd6);

    for (int i = 0; i < 150; i++) begin
      push(24'h800000);
      push(24'h800000);
      exp_sat += 2;
      if (i == 0) begin
        check("sat_first", sat_cnt, exp_sat);
      end
      run_chk("sat", 24'hFFFFFF, 24'hFFFFFF);
    end
    check("sat_sticky", sat_cnt, (exp_sat > 255) ? 255 : exp_sat);

    push(24'h001234);
    push(24'hFF0000);
    begin
      int n;
      n = 0;
      while (!kf_start && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("mr_start", kf_start, 1);
    end
    @(negedge clk);
    check("mr_load", kf_data, 24'h001234);
    rst_n = 1'b0;
    #1;
    check("mr_start0", kf_start, 0);
    check("mr_data0", kf_data, 0);
    check("mr_busy0", busy, 0);
    check("mr_empty", s_ready, 1);
    check("mr_sat0", sat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_no_start", kf_start, 0);
    check("mr_fifo_lost", kf_data, 0);
    check("mr_idle", busy, 0);
    push(24'h001234);
    push(24'hFF0000);
    run_chk("mr_fresh", 24'h001234, 24'h810000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
